// File: rtl/imm_gen_pkg.sv
// rtl/imm_gen_pkg.sv - shared encodings and field positions for the immediate generator
//
// Purpose: format select encodings, instruction field bit positions and a
// sign-extension helper shared by the decoder, the pipe and its interface.
// Ports: none (package).

package imm_gen_pkg;

  localparam int INSTR_W = 32;
  localparam int CTRL_W  = 3;

  typedef enum logic [CTRL_W-1:0] {
    IMM_I  = 3'b000,
    IMM_D  = 3'b001,
    IMM_B  = 3'b010,
    IMM_CB = 3'b011,
    IMM_IW = 3'b100
  } imm_fmt_e;

  // Immediate field positions inside the instruction word
  localparam int I_LSB  = 10;
  localparam int I_MSB  = 21;
  localparam int D_LSB  = 12;
  localparam int D_MSB  = 20;
  localparam int B_LSB  = 0;
  localparam int B_MSB  = 25;
  localparam int CB_LSB = 5;
  localparam int CB_MSB = 23;
  localparam int IW_LSB = 5;
  localparam int IW_MSB = 20;

  // MOVZ-style half-word select
  localparam int IW_HW_LSB = 21;
  localparam int IW_HW_MSB = 22;

  // Sign-extend the low 'width' bits of v to 64 bits
  function automatic logic [63:0] sext64(input logic [63:0] v, input int width);
    logic [63:0] t;
    t = v << (64 - width);
    return $signed(t) >>> (64 - width);
  endfunction

endpackage

// File: rtl/imm_gen_pipe_if.sv
// rtl/imm_gen_pipe_if.sv - valid/ready bundle between decode, the immediate pipe and execute
//
// Purpose: groups the instruction input handshake and the result output
// handshake of imm_gen_pipe.
// Ports (signals):
//   in_valid/in_ready/in_instr/in_ctrl   - instruction + format offer
//   out_valid/out_ready/out_imm/out_err  - extended immediate result
// Modports: master = producer/consumer side, slave = imm_gen_pipe.

interface imm_gen_pipe_if
  import imm_gen_pkg::*;
#(
  parameter int DATA_W = 64
);
  logic               in_valid;
  logic               in_ready;
  logic [INSTR_W-1:0] in_instr;
  logic [CTRL_W-1:0]  in_ctrl;
  logic               out_valid;
  logic               out_ready;
  logic [DATA_W-1:0]  out_imm;
  logic               out_err;

  modport master (
    output in_valid, in_instr, in_ctrl, out_ready,
    input  in_ready, out_valid, out_imm, out_err
  );

  modport slave (
    input  in_valid, in_instr, in_ctrl, out_ready,
    output in_ready, out_valid, out_imm, out_err
  );
endinterface

// File: rtl/imm_gen_decode.sv
// rtl/imm_gen_decode.sv - combinational immediate extraction and extension
//
// Purpose: turns (instruction, format select) into an extended immediate and
// an error flag for illegal formats or IW shifts beyond DATA_W.
// Ports:
//   instr_i  in  32      instruction word
//   ctrl_i   in  3       format select (imm_fmt_e)
//   imm_o    out DATA_W  extended immediate, zero on error
//   err_o    out 1       illegal ctrl or IW half-word out of range

module imm_gen_decode
  import imm_gen_pkg::*;
#(
  parameter int DATA_W   = 64,
  parameter int SHIFT_BR = 0
) (
  input  logic [INSTR_W-1:0] instr_i,
  input  logic [CTRL_W-1:0]  ctrl_i,
  output logic [DATA_W-1:0]  imm_o,
  output logic               err_o
);

  // Everything is built at 64 bits; sign extension to 64 then truncating to
  // 32 is identical to sign extension straight to 32.
  logic [63:0] wide;
  logic [1:0]  hw;
  logic        unused_bits;

  assign hw = instr_i[IW_HW_MSB:IW_HW_LSB];

  always_comb begin
    wide  = '0;
    err_o = 1'b0;
    case (ctrl_i)
      IMM_I:  wide = {52'b0, instr_i[I_MSB:I_LSB]};
      IMM_D:  wide = sext64({55'b0, instr_i[D_MSB:D_LSB]}, 9);
      IMM_B: begin
        if (SHIFT_BR != 0) wide = sext64({36'b0, instr_i[B_MSB:B_LSB], 2'b00}, 28);
        else               wide = sext64({38'b0, instr_i[B_MSB:B_LSB]}, 26);
      end
      IMM_CB: begin
        if (SHIFT_BR != 0) wide = sext64({43'b0, instr_i[CB_MSB:CB_LSB], 2'b00}, 21);
        else               wide = sext64({45'b0, instr_i[CB_MSB:CB_LSB]}, 19);
      end
      IMM_IW: begin
        // In a 32-bit result only half-words 0 and 1 exist
        if (DATA_W == 32 && hw[1]) err_o = 1'b1;
        else wide = {48'b0, instr_i[IW_MSB:IW_LSB]} << {hw, 4'b0000};
      end
      default: err_o = 1'b1;
    endcase
  end

  assign imm_o = wide[DATA_W-1:0];

  // Opcode bits and the upper half of 'wide' in 32-bit builds are not needed
  assign unused_bits = ^{instr_i[31:26], wide};

endmodule

// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - pipelined immediate generator with output and skid registers
//
// Purpose: decodes an accepted instruction into its immediate one cycle later,
// keeping full throughput under backpressure via a single skid entry.
// Ports:
//   CLK    in     rising-edge clock
//   Reset  in     synchronous active-high reset
//   bus    slave  in_valid/in_ready/in_instr/in_ctrl, out_valid/out_ready/out_imm/out_err

module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int DATA_W   = 64,
  parameter int SHIFT_BR = 0
) (
  input  logic           CLK,
  input  logic           Reset,
  imm_gen_pipe_if.slave  bus
);

  logic [DATA_W-1:0] dec_imm;
  logic              dec_err;

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_imm_q, out_imm_d;
  logic              out_err_q, out_err_d;
  logic              skid_valid_q, skid_valid_d;
  logic [DATA_W-1:0] skid_imm_q, skid_imm_d;
  logic              skid_err_q, skid_err_d;
  logic              in_ready_q, in_ready_d;

  logic              accept;
  logic              out_free;

  imm_gen_decode #(
    .DATA_W  (DATA_W),
    .SHIFT_BR(SHIFT_BR)
  ) u_decode (
    .instr_i(bus.in_instr),
    .ctrl_i (bus.in_ctrl),
    .imm_o  (dec_imm),
    .err_o  (dec_err)
  );

  always_comb begin
    out_valid_d  = out_valid_q;
    out_imm_d    = out_imm_q;
    out_err_d    = out_err_q;
    skid_valid_d = skid_valid_q;
    skid_imm_d   = skid_imm_q;
    skid_err_d   = skid_err_q;

    accept   = bus.in_valid && in_ready_q;
    out_free = !out_valid_q || bus.out_ready;

    if (out_free) begin
      if (skid_valid_q) begin
        // in_ready is low whenever skid is full, so no accept competes here
        out_valid_d  = 1'b1;
        out_imm_d    = skid_imm_q;
        out_err_d    = skid_err_q;
        skid_valid_d = 1'b0;
        skid_imm_d   = '0;
        skid_err_d   = 1'b0;
      end else if (accept) begin
        out_valid_d = 1'b1;
        out_imm_d   = dec_imm;
        out_err_d   = dec_err;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_imm_d   = dec_imm;
      skid_err_d   = dec_err;
    end

    // Registered ready: follows the next skid state, never out_ready directly
    in_ready_d = !skid_valid_d;
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      out_valid_q  <= 1'b0;
      out_imm_q    <= '0;
      out_err_q    <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_imm_q   <= '0;
      skid_err_q   <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      out_valid_q  <= out_valid_d;
      out_imm_q    <= out_imm_d;
      out_err_q    <= out_err_d;
      skid_valid_q <= skid_valid_d;
      skid_imm_q   <= skid_imm_d;
      skid_err_q   <= skid_err_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_imm   = out_imm_q;
  assign bus.out_err   = out_err_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb/tb_imm_gen_pipe.sv - directed and random checks of imm_gen_pipe in 64- and 32-bit builds

module tb_imm_gen_pipe;

  logic CLK;
  logic Reset;

  int n_checks;
  int n_pass;

  logic [63:0] exp_q[$];

  imm_gen_pipe_if #(.DATA_W(64)) b64();
  imm_gen_pipe_if #(.DATA_W(32)) b32();

  imm_gen_pipe #(.DATA_W(64), .SHIFT_BR(1)) dut64 (
    .CLK  (CLK),
    .Reset(Reset),
    .bus  (b64)
  );

  imm_gen_pipe #(.DATA_W(32), .SHIFT_BR(0)) dut32 (
    .CLK  (CLK),
    .Reset(Reset),
    .bus  (b32)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Called at a negedge; offers one instruction and checks it one cycle later
  task automatic one64(input string tag, input logic [31:0] instr, input logic [2:0] ctrl,
                       input logic [63:0] exp_imm, input logic exp_err);
    b64.in_valid = 1'b1;
    b64.in_instr = instr;
    b64.in_ctrl  = ctrl;
    @(negedge CLK);
    check({tag, "_valid"}, 64'(b64.out_valid), 64'd1);
    check({tag, "_imm"},   b64.out_imm, exp_imm);
    check({tag, "_err"},   64'(b64.out_err), 64'(exp_err));
    b64.in_valid = 1'b0;
  endtask

  task automatic one32(input string tag, input logic [31:0] instr, input logic [2:0] ctrl,
                       input logic [31:0] exp_imm, input logic exp_err);
    b32.in_valid = 1'b1;
    b32.in_instr = instr;
    b32.in_ctrl  = ctrl;
    @(negedge CLK);
    check({tag, "_valid"}, 64'(b32.out_valid), 64'd1);
    check({tag, "_imm"},   64'(b32.out_imm), 64'(exp_imm));
    check({tag, "_err"},   64'(b32.out_err), 64'(exp_err));
    b32.in_valid = 1'b0;
  endtask

  // One random cycle on dut64, entered at a negedge; model is a FIFO of expected results
  task automatic rnd_cycle(input logic drive_rand);
    logic [31:0] instr;
    logic [63:0] exp;
    logic [8:0]  r9;
    logic        acc;
    logic        xfer;
    if (drive_rand) begin
      instr = $urandom;
      b64.in_valid  = ($urandom_range(0, 3) != 0);
      b64.out_ready = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 1) == 1) begin
        r9 = instr[20:12];
        b64.in_ctrl = 3'b001;
        exp = {{55{r9[8]}}, r9};
      end else begin
        b64.in_ctrl = 3'b000;
        exp = {52'b0, instr[21:10]};
      end
      b64.in_instr = instr;
    end else begin
      b64.in_valid  = 1'b0;
      b64.out_ready = 1'b1;
      exp = '0;
    end
    check("rnd_out_valid", 64'(b64.out_valid), 64'(exp_q.size() != 0));
    check("rnd_in_ready",  64'(b64.in_ready),  64'(exp_q.size() < 2));
    acc  = b64.in_valid && b64.in_ready;
    xfer = b64.out_valid && b64.out_ready;
    if (xfer && exp_q.size() != 0) check("rnd_data", b64.out_imm, exp_q.pop_front());
    if (acc) exp_q.push_back(exp);
    @(negedge CLK);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    Reset = 1'b1;
    b64.in_valid = 1'b0; b64.in_instr = '0; b64.in_ctrl = '0; b64.out_ready = 1'b1;
    b32.in_valid = 1'b0; b32.in_instr = '0; b32.in_ctrl = '0; b32.out_ready = 1'b1;
    repeat (2) @(negedge CLK);
    Reset = 1'b0;

    check("rst_out_valid", 64'(b64.out_valid), 64'd0);
    check("rst_in_ready",  64'(b64.in_ready),  64'd1);
    check("rst_out_imm",   b64.out_imm,        64'd0);
    check("rst_out_err",   64'(b64.out_err),   64'd0);

    // 64-bit build, SHIFT_BR = 1
    one64("i_fff",    32'h0000_0FFF << 10, 3'b000, 64'h0000_0000_0000_0FFF, 1'b0);
    one64("i_ones",   32'hFFFF_FFFF,        3'b000, 64'h0000_0000_0000_0FFF, 1'b0);
    one64("d_neg16",  32'h0000_01F0 << 12, 3'b001, 64'hFFFF_FFFF_FFFF_FFF0, 1'b0);
    one64("d_pos",    32'h0000_00FF << 12, 3'b001, 64'h0000_0000_0000_00FF, 1'b0);
    one64("b_m1_sh",  32'h03FF_FFFF,        3'b010, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
    one64("cb_sh",    32'h0000_0010 << 5,  3'b011, 64'h0000_0000_0000_0040, 1'b0);
    one64("iw_hw3",   (32'd3 << 21) | (32'h1234 << 5), 3'b100, 64'h1234_0000_0000_0000, 1'b0);
    one64("ctrl_111", 32'hFFFF_FFFF,        3'b111, 64'd0, 1'b1);

    // 32-bit build, SHIFT_BR = 0
    one32("cb_10",     32'h0000_0010 << 5,  3'b011, 32'h0000_0010, 1'b0);
    one32("cb_neg",    32'h0004_0000 << 5,  3'b011, 32'hFFFC_0000, 1'b0);
    one32("b_neg",     32'h0200_0000,        3'b010, 32'hFE00_0000, 1'b0);
    one32("iw32_hw1",  (32'd1 << 21) | (32'h1234 << 5), 3'b100, 32'h1234_0000, 1'b0);
    one32("iw32_hw2",  (32'd2 << 21) | (32'h1234 << 5), 3'b100, 32'h0, 1'b1);
    one32("ctrl_101",  32'h0000_0FFF << 10, 3'b101, 32'h0, 1'b1);

    // Backpressure: values 1..4, out_ready low for three cycles
    @(negedge CLK);
    b64.out_ready = 1'b0;
    b64.in_ctrl   = 3'b000;
    b64.in_valid  = 1'b1;
    b64.in_instr  = 32'd1 << 10;
    @(negedge CLK);
    check("bp_1_out",   b64.out_imm, 64'd1);
    check("bp_1_ready", 64'(b64.in_ready), 64'd1);
    b64.in_instr = 32'd2 << 10;
    @(negedge CLK);
    check("bp_2_ready", 64'(b64.in_ready), 64'd0);
    check("bp_2_hold",  b64.out_imm, 64'd1);
    b64.in_instr = 32'd3 << 10;
    @(negedge CLK);
    check("bp_3_hold",  b64.out_imm, 64'd1);
    check("bp_3_valid", 64'(b64.out_valid), 64'd1);
    b64.out_ready = 1'b1;
    @(negedge CLK);
    check("bp_out2",    b64.out_imm, 64'd2);
    check("bp_4_ready", 64'(b64.in_ready), 64'd1);
    @(negedge CLK);
    check("bp_out3",    b64.out_imm, 64'd3);
    b64.in_instr = 32'd4 << 10;
    @(negedge CLK);
    check("bp_out4",    b64.out_imm, 64'd4);
    b64.in_valid = 1'b0;
    @(negedge CLK);
    check("bp_empty",   64'(b64.out_valid), 64'd0);

    // Reset with output and skid both full
    b64.out_ready = 1'b0;
    b64.in_valid  = 1'b1;
    b64.in_instr  = 32'h11 << 10;
    @(negedge CLK);
    b64.in_instr  = 32'h22 << 10;
    @(negedge CLK);
    check("full_ready", 64'(b64.in_ready), 64'd0);
    Reset = 1'b1;
    b64.in_instr = 32'h33 << 10;
    @(negedge CLK);
    Reset = 1'b0;
    b64.in_valid = 1'b0;
    check("mrst_valid", 64'(b64.out_valid), 64'd0);
    check("mrst_ready", 64'(b64.in_ready),  64'd1);
    check("mrst_imm",   b64.out_imm,        64'd0);
    b64.out_ready = 1'b1;
    b64.in_valid  = 1'b1;
    b64.in_instr  = 32'h44 << 10;
    @(negedge CLK);
    check("post_rst_valid", 64'(b64.out_valid), 64'd1);
    check("post_rst_imm",   b64.out_imm,        64'h44);
    b64.in_valid = 1'b0;
    @(negedge CLK);
    check("post_rst_drain", 64'(b64.out_valid), 64'd0);

    // Random valid/ready against a FIFO reference model
    exp_q.delete();
    for (int c = 0; c < 10000; c++) rnd_cycle(1'b1);
    for (int c = 0; c < 4; c++) rnd_cycle(1'b0);
    check("rnd_drained", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
